// File: rtl/genius_uc.sv
// Control unit for the Genius memory game: Moore FSM sequencing display, play capture and comparison.
// Outputs are registered from the next state, so they stay aligned with db_estado.
module genius_uc (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       jogada_feita,
   input  logic       botoesIgualMemoria,
   input  logic       endecoIgualLimite,
   input  logic       fimL,
   input  logic       fimM,
   input  logic       timeout,
   output logic       zeraE,
   output logic       contaE,
   output logic       zeraL,
   output logic       contaL,
   output logic       zeraM,
   output logic       contaM,
   output logic       zeraR,
   output logic       registraR,
   output logic       selecionaMemoria,
   output logic       reset_random,
   output logic       contaT,
   output logic [1:0] seletor,
   output logic       pronto,
   output logic       acertou,
   output logic       errou,
   output logic       db_timeout,
   output logic [3:0] db_estado
);

   localparam int unsigned CTRL_W = 17;

   localparam logic [3:0] INICIAL          = 4'h0;
   localparam logic [3:0] PREPARACAO       = 4'h1;
   localparam logic [3:0] NOVA_SEQUENCIA   = 4'h2;
   localparam logic [3:0] MOSTRA           = 4'h3;
   localparam logic [3:0] APAGA            = 4'h4;
   localparam logic [3:0] PROXIMO_MOSTRA   = 4'h5;
   localparam logic [3:0] ZERA_JOGADAS     = 4'h6;
   localparam logic [3:0] ESPERA_JOGADA    = 4'h7;
   localparam logic [3:0] REGISTRA         = 4'h8;
   localparam logic [3:0] COMPARA          = 4'h9;
   localparam logic [3:0] PROXIMA_JOGADA   = 4'hA;
   localparam logic [3:0] ULTIMA_SEQUENCIA = 4'hB;
   localparam logic [3:0] FIM_ACERTOU      = 4'hC;
   localparam logic [3:0] FIM_ERROU        = 4'hD;
   localparam logic [3:0] FIM_TIMEOUT      = 4'hE;

   // Bit positions of the packed control word
   localparam int unsigned B_DB_TIMEOUT = 0;
   localparam int unsigned B_ERROU      = 1;
   localparam int unsigned B_ACERTOU    = 2;
   localparam int unsigned B_PRONTO     = 3;
   localparam int unsigned B_SEL_LO     = 4;
   localparam int unsigned B_SEL_HI     = 5;
   localparam int unsigned B_CONTA_T    = 6;
   localparam int unsigned B_RST_RANDOM = 7;
   localparam int unsigned B_SEL_MEM    = 8;
   localparam int unsigned B_REGISTRA_R = 9;
   localparam int unsigned B_ZERA_R     = 10;
   localparam int unsigned B_CONTA_M    = 11;
   localparam int unsigned B_ZERA_M     = 12;
   localparam int unsigned B_CONTA_L    = 13;
   localparam int unsigned B_ZERA_L     = 14;
   localparam int unsigned B_CONTA_E    = 15;
   localparam int unsigned B_ZERA_E     = 16;

   logic [3:0]        state_q, state_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         INICIAL:          if (iniciar) state_d = PREPARACAO;
         PREPARACAO:       state_d = NOVA_SEQUENCIA;
         NOVA_SEQUENCIA:   state_d = MOSTRA;
         MOSTRA:           if (fimM) state_d = APAGA;
         APAGA:            if (fimM) state_d = endecoIgualLimite ? ZERA_JOGADAS : PROXIMO_MOSTRA;
         PROXIMO_MOSTRA:   state_d = MOSTRA;
         ZERA_JOGADAS:     state_d = ESPERA_JOGADA;
         ESPERA_JOGADA: begin
            if (jogada_feita) state_d = REGISTRA;
            else if (timeout) state_d = FIM_TIMEOUT;
         end
         REGISTRA:         state_d = COMPARA;
         COMPARA: begin
            if (!botoesIgualMemoria)    state_d = FIM_ERROU;
            else if (endecoIgualLimite) state_d = ULTIMA_SEQUENCIA;
            else                        state_d = PROXIMA_JOGADA;
         end
         PROXIMA_JOGADA:   state_d = ESPERA_JOGADA;
         ULTIMA_SEQUENCIA: state_d = fimL ? FIM_ACERTOU : NOVA_SEQUENCIA;
         FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT:
                           if (iniciar) state_d = PREPARACAO;
         default:          state_d = INICIAL;
      endcase
   end

   // Moore output decode of the upcoming state, registered alongside it
   always_comb begin
      ctrl_d = '0;
      case (state_d)
         PREPARACAO: begin
            ctrl_d[B_ZERA_E]     = 1'b1;
            ctrl_d[B_ZERA_L]     = 1'b1;
            ctrl_d[B_ZERA_M]     = 1'b1;
            ctrl_d[B_ZERA_R]     = 1'b1;
            ctrl_d[B_RST_RANDOM] = 1'b1;
            ctrl_d[B_SEL_MEM]    = 1'b1;
         end
         NOVA_SEQUENCIA: begin
            ctrl_d[B_ZERA_E] = 1'b1;
            ctrl_d[B_ZERA_M] = 1'b1;
         end
         MOSTRA: begin
            ctrl_d[B_SEL_LO]  = 1'b1;
            ctrl_d[B_CONTA_M] = 1'b1;
         end
         APAGA:            ctrl_d[B_CONTA_M] = 1'b1;
         PROXIMO_MOSTRA:   ctrl_d[B_CONTA_E] = 1'b1;
         ZERA_JOGADAS: begin
            ctrl_d[B_ZERA_E] = 1'b1;
            ctrl_d[B_ZERA_R] = 1'b1;
         end
         ESPERA_JOGADA: begin
            ctrl_d[B_SEL_HI]  = 1'b1;
            ctrl_d[B_CONTA_T] = 1'b1;
         end
         REGISTRA: begin
            ctrl_d[B_SEL_HI]     = 1'b1;
            ctrl_d[B_REGISTRA_R] = 1'b1;
         end
         COMPARA:          ctrl_d[B_SEL_HI]  = 1'b1;
         PROXIMA_JOGADA:   ctrl_d[B_CONTA_E] = 1'b1;
         ULTIMA_SEQUENCIA: ctrl_d[B_CONTA_L] = 1'b1;
         FIM_ACERTOU: begin
            ctrl_d[B_PRONTO]  = 1'b1;
            ctrl_d[B_ACERTOU] = 1'b1;
            ctrl_d[B_SEL_LO]  = 1'b1;
         end
         FIM_ERROU: begin
            ctrl_d[B_PRONTO] = 1'b1;
            ctrl_d[B_ERROU]  = 1'b1;
         end
         FIM_TIMEOUT: begin
            ctrl_d[B_PRONTO]     = 1'b1;
            ctrl_d[B_ERROU]      = 1'b1;
            ctrl_d[B_DB_TIMEOUT] = 1'b1;
         end
         default:          ctrl_d = '0;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= INICIAL;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign zeraE            = ctrl_q[B_ZERA_E];
   assign contaE           = ctrl_q[B_CONTA_E];
   assign zeraL            = ctrl_q[B_ZERA_L];
   assign contaL           = ctrl_q[B_CONTA_L];
   assign zeraM            = ctrl_q[B_ZERA_M];
   assign contaM           = ctrl_q[B_CONTA_M];
   assign zeraR            = ctrl_q[B_ZERA_R];
   assign registraR        = ctrl_q[B_REGISTRA_R];
   assign selecionaMemoria = ctrl_q[B_SEL_MEM];
   assign reset_random     = ctrl_q[B_RST_RANDOM];
   assign contaT           = ctrl_q[B_CONTA_T];
   assign seletor          = ctrl_q[B_SEL_HI:B_SEL_LO];
   assign pronto           = ctrl_q[B_PRONTO];
   assign acertou          = ctrl_q[B_ACERTOU];
   assign errou            = ctrl_q[B_ERROU];
   assign db_timeout       = ctrl_q[B_DB_TIMEOUT];
   assign db_estado        = state_q;

endmodule

// File: doc/genius_uc.md
GENIUS_UC -- requirements
Module: genius_uc

Interface
REQ-001 The block SHALL have no parameters; state encoding and timing are fixed by this document.
REQ-002 The block SHALL have a single clock and an asynchronous active-low reset.
REQ-003 The ports SHALL be:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- iniciar  in  1  start/restart request
- jogada_feita  in  1  one-cycle pulse, button pressed
- botoesIgualMemoria  in  1  registered play equals memory
- endecoIgualLimite  in  1  address equals round limit
- fimL  in  1  limit counter at last round
- fimM  in  1  display-interval counter terminal count
- timeout  in  1  play timeout expired
- zeraE, contaE  out  1 each  address counter clear / count
- zeraL, contaL  out  1 each  limit counter clear / count
- zeraM, contaM  out  1 each  display counter clear / count
- zeraR, registraR  out  1 each  play register clear / load
- selecionaMemoria  out  1  latch random memory choice
- reset_random  out  1  reset random generator
- contaT  out  1  enable timeout counter; low clears it
- seletor  out  2  LED mux: 00 off, 01 memory, 10 buttons
- pronto, acertou, errou  out  1 each  game-over, win, loss
- db_timeout  out  1  loss caused by timeout
- db_estado  out  4  current state code

Function
REQ-004 Moore FSM; every output SHALL be a function of the state only; unlisted outputs are 0 in each state.
REQ-005 States and codes (hex):
- 0 inicial
- 1 preparacao
- 2 nova_sequencia
- 3 mostra
- 4 apaga
- 5 proximo_mostra
- 6 zera_jogadas
- 7 espera_jogada
- 8 registra
- 9 compara
- A proxima_jogada
- B ultima_sequencia
- C fim_acertou
- D fim_errou
- E fim_timeout
REQ-006 Unused code F SHALL go to inicial on the next clock.
REQ-007 inicial: all outputs 0; iniciar=1 -> preparacao.
REQ-008 preparacao: zeraE, zeraL, zeraM, zeraR, reset_random, selecionaMemoria = 1; unconditional -> nova_sequencia.
REQ-009 nova_sequencia: zeraE, zeraM = 1; -> mostra.
REQ-010 mostra: seletor=01, contaM=1; fimM -> apaga, else stay.
REQ-011 apaga: seletor=00, contaM=1; on fimM: endecoIgualLimite -> zera_jogadas, else -> proximo_mostra; stay while fimM=0.
REQ-012 proximo_mostra: contaE=1 for exactly one cycle; -> mostra.
REQ-013 zera_jogadas: zeraE, zeraR = 1; -> espera_jogada.
REQ-014 espera_jogada: seletor=10, contaT=1.
- jogada_feita -> registra.
- else timeout -> fim_timeout.
- jogada_feita has priority when both are asserted in the same cycle.
REQ-015 registra: registraR=1, seletor=10; -> compara.
REQ-016 compara: seletor=10.
- botoesIgualMemoria=0 -> fim_errou.
- else endecoIgualLimite=1 -> ultima_sequencia.
- else -> proxima_jogada.
REQ-017 proxima_jogada: contaE=1 for one cycle; -> espera_jogada, so contaT drops one cycle and the timeout restarts per play.
REQ-018 ultima_sequencia: fimL=1 -> fim_acertou; else contaL=1 for one cycle and -> nova_sequencia.
REQ-019 fim_acertou: pronto=1, acertou=1, seletor=01.
REQ-020 fim_errou: pronto=1, errou=1.
REQ-021 fim_timeout: pronto=1, errou=1, db_timeout=1.
REQ-022 From any fim_* state: iniciar=1 -> preparacao, else stay; iniciar SHALL be ignored in all other states.
REQ-023 Latency: every unconditional transition SHALL take exactly one clock; conditional states hold indefinitely until their condition is met.

Reset
REQ-024 reset=0 SHALL force state inicial immediately, independent of clock, including mid-display or mid-play.
REQ-025 While reset=0, all outputs SHALL be 0 and db_estado SHALL be 0.
REQ-026 The first clock edge after reset deasserts SHALL evaluate inicial's transition.

Verification
REQ-027 Reset, then iniciar pulse -> db_estado sequence 0,1,2,3; zeraL=1 for exactly the preparacao cycle.
REQ-028 Round 1: limite=0, fimM pulses -> mostra(seletor=01), apaga(seletor=00), zera_jogadas, espera_jogada(contaT=1); correct jogada -> 8,9,B; fimL=0 -> contaL one cycle, then state 2.
REQ-029 Round 2: with endecoIgualLimite=0 in compara -> state A with contaE=1 one cycle, then state 7.
REQ-030 Wrong play: botoesIgualMemoria=0 in compara -> state D with pronto=1 and errou=1; iniciar -> state 1.
REQ-031 Timeout: timeout=1 in espera_jogada -> state E with errou=1 and db_timeout=1; jogada_feita and timeout asserted together -> state 8.
REQ-032 Async reset asserted in state 3, off clock edge -> db_estado=0 and all outputs 0 before the next edge.
